// File: rtl/memory_dp_param.sv
`default_nettype none
// ============================================================================
// Module  : memory_dp_param
// Purpose : Simple dual-port RAM (one write port, one read port) with
//           per-byte write enables, a 2-cycle registered read with a valid
//           flag, selectable read-during-write bypass and an optional
//           post-reset clear sequence that zeroes every word.
// Ports   : clk, reset       - clock, synchronous active-high reset
//           wr_vld/wr_address/wr_data/wr_be - write request, byte enables
//           rd_vld/rd_address                - read request
//           ready            - low while the clear sequence runs
//           rd_data/rd_data_vld              - registered read result
// Revision: 1.0 - initial release
// ============================================================================
module memory_dp_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 9,
  parameter int ADDR_W     = 4,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_vld,
  input  logic [ADDR_W-1:0]    wr_address,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic                 rd_vld,
  input  logic [ADDR_W-1:0]    rd_address,
  output logic                 ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_data_vld
);

  localparam int                NBYTES    = WIDTH / 8;
  // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_data_vld_q, rd_data_vld_d;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    be_mask;
  logic                wr_en;
  logic                clr_en;
  logic                rd_in_range;
  logic                collide;
  logic [WIDTH-1:0]    old_word;
  logic [WIDTH-1:0]    rd_word;

  assign ready       = (state_q == S_IDLE);
  assign rd_data     = rd_data_q;
  assign rd_data_vld = rd_data_vld_q;

  // Out-of-range writes are dropped rather than wrapped onto a real word.
  assign wr_en  = ready & wr_vld & ({1'b0, wr_address} < DEPTH_W);
  assign clr_en = (state_q == S_CLEAR) & ~reset;

  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
      assign be_mask[8*i +: 8] = {8{wr_be[i]}};
    end
  endgenerate

  // Storage: the clear sequence owns the array while it runs (ready is low,
  // so wr_en cannot fire at the same time).
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[wr_address] <= (mem[wr_address] & ~be_mask) | (wr_data & be_mask);
    end
  end

  // Second read stage: the array is sampled at the same edge a write may
  // land, so without forwarding the result is the pre-write word.
  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_W);
  assign old_word    = rd_in_range ? mem[rd_addr_q] : '0;

  generate
    if (BYPASS != 0) begin : g_bypass
      assign collide = wr_en & (wr_address == rd_addr_q);
    end else begin : g_no_bypass
      assign collide = 1'b0;
    end
  endgenerate

  assign rd_word = collide ? ((old_word & ~be_mask) | (wr_data & be_mask))
                           : old_word;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_addr_d     = rd_addr_q;
    rd_pend_d     = 1'b0;
    rd_data_d     = rd_data_q;
    rd_data_vld_d = 1'b0;

    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    // First read stage: capture the request.
    if (ready && rd_vld) begin
      rd_addr_d = rd_address;
      rd_pend_d = 1'b1;
    end

    // Second read stage: produce exactly one valid result per request.
    if (rd_pend_q) begin
      rd_data_d     = rd_word;
      rd_data_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
      cnt_q         <= '0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_pend_q     <= rd_pend_d;
      rd_data_q     <= rd_data_d;
      rd_data_vld_q <= rd_data_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_dp_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_dp_param
// Purpose : Self-checking bench for memory_dp_param. Two instances share the
//           stimulus: one with read-during-write bypass, one without. A
//           reference array predicts every read result, which is queued
//           with the cycle it must appear in and compared by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_dp_param;

  localparam int DEPTH = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_vld = 1'b0;
  logic [3:0]  wr_address = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_vld = 1'b0;
  logic [3:0]  rd_address = '0;

  logic        ready_b, ready_n;
  logic [31:0] rd_data_b, rd_data_n;
  logic        rd_data_vld_b, rd_data_vld_n;

  memory_dp_param #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(4), .BYPASS(1), .INIT_CLEAR(1)) u_dut_byp (
    .clk(clk), .reset(reset), .wr_vld(wr_vld), .wr_address(wr_address),
    .wr_data(wr_data), .wr_be(wr_be), .rd_vld(rd_vld), .rd_address(rd_address),
    .ready(ready_b), .rd_data(rd_data_b), .rd_data_vld(rd_data_vld_b)
  );

  memory_dp_param #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_W(4), .BYPASS(0), .INIT_CLEAR(1)) u_dut_nobyp (
    .clk(clk), .reset(reset), .wr_vld(wr_vld), .wr_address(wr_address),
    .wr_data(wr_data), .wr_be(wr_be), .rd_vld(rd_vld), .rd_address(rd_address),
    .ready(ready_n), .rd_data(rd_data_n), .rd_data_vld(rd_data_vld_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] exp_byp;
    logic [31:0] exp_nobyp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mem_m [16];
  bit          ready_m = 1'b0;
  bit          prev_pend = 1'b0;
  logic [3:0]  prev_addr = '0;
  int          cyc = 0;
  bit          started = 1'b0;
  logic [31:0] last_b = '0;
  logic [31:0] last_n = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Drive one clock cycle of stimulus and advance the reference model.
  task automatic cycle(input bit wv, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input bit rv, input logic [3:0] ra);
    sb_t         e;
    logic [31:0] old;
    wr_vld = wv; wr_address = wa; wr_data = wd; wr_be = wbe;
    rd_vld = rv; rd_address = ra;
    if (prev_pend) begin
      old = (prev_addr < DEPTH) ? mem_m[prev_addr] : 32'h0;
      e.due       = cyc + 1;
      e.exp_nobyp = old;
      e.exp_byp   = (ready_m && wv && wa < DEPTH && wa == prev_addr) ? merge(old, wd, wbe) : old;
      sb.push_back(e);
    end
    if (ready_m && wv && wa < DEPTH) mem_m[wa] = merge(mem_m[wa], wd, wbe);
    prev_pend = ready_m && rv;
    prev_addr = ra;
    @(posedge clk);
    #1;
    wr_vld = 1'b0;
    rd_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic apply_reset();
    reset = 1'b1; wr_vld = 1'b0; rd_vld = 1'b0;
    prev_pend = 1'b0; ready_m = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_b = 32'h0; last_n = 32'h0;
    check("rst_ready", {31'h0, ready_b}, 32'h0);
    check("rst_vld", {31'h0, rd_data_vld_b}, 32'h0);
    check("rst_rd_data", rd_data_b, 32'h0);
  endtask

  // Clear cycles; the last one carries a write and a read that must be dropped.
  task automatic run_clear(input int n);
    for (int i = 0; i < n; i++) begin
      check("clr_ready_b", {31'h0, ready_b}, 32'h0);
      check("clr_ready_n", {31'h0, ready_n}, 32'h0);
      cycle(i == n - 1, 4'h2, 32'hFFFF_FFFF, 4'hF, i == n - 1, 4'h2);
    end
  endtask

  task automatic wait_ready();
    run_clear(DEPTH);
    check("ready_rise_b", {31'h0, ready_b}, 32'h1);
    check("ready_rise_n", {31'h0, ready_n}, 32'h1);
    ready_m = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
  endtask

  // Monitor: every cycle either a due result or an idle/held output.
  always @(negedge clk) begin
    if (started) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        check("result_missing", 32'h0, 32'h1);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("vld_byp", {31'h0, rd_data_vld_b}, 32'h1);
        check("vld_nobyp", {31'h0, rd_data_vld_n}, 32'h1);
        check("data_byp", rd_data_b, sb[0].exp_byp);
        check("data_nobyp", rd_data_n, sb[0].exp_nobyp);
        last_b = sb[0].exp_byp;
        last_n = sb[0].exp_nobyp;
        void'(sb.pop_front());
      end else begin
        check("idle_vld_byp", {31'h0, rd_data_vld_b}, 32'h0);
        check("idle_vld_nobyp", {31'h0, rd_data_vld_n}, 32'h0);
        if (!reset) begin
          check("hold_byp", rd_data_b, last_b);
          check("hold_nobyp", rd_data_n, last_n);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clear after reset, then every word reads zero.
    apply_reset();
    wait_ready();
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(3);

    // Byte enables.
    cycle(1'b1, 4'h3, 32'hDEAD_BEEF, 4'hF, 1'b0, 4'h0);
    cycle(1'b1, 4'h3, 32'h1122_3344, 4'b0101, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3);
    idle(3);

    // Read-during-write collision, then a re-read.
    cycle(1'b1, 4'h5, 32'hAAAA_AAAA, 4'hF, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5);
    cycle(1'b1, 4'h5, 32'h5555_5555, 4'hF, 1'b0, 4'h0);
    idle(2);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5);
    idle(3);

    // Partial-byte collision.
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5);
    cycle(1'b1, 4'h5, 32'h0F0F_0F0F, 4'b1001, 1'b0, 4'h0);
    idle(3);

    // Streaming reads at full throughput.
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 4'(a), 32'(a) * 32'h0101_0101, 4'hF, 1'b0, 4'h0);
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
    idle(3);

    // Out-of-range write/read, and no aliasing onto real words.
    cycle(1'b1, 4'd12, 32'hCAFE_F00D, 4'hF, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd12);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd3);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd4);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd15);
    idle(3);

    // Reset in the middle of a read, then again part way through the clear.
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1);
    apply_reset();
    run_clear(4);
    apply_reset();
    wait_ready();
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h2);
    idle(3);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
